// File: rtl/fifo_alu_sequencer_pkg.sv
// Shared constants for the RX FIFO -> ALU -> TX FIFO transaction sequencer:
// default word/opcode widths and the 3-bit state encoding.
package fifo_alu_sequencer_pkg;

    localparam int NB_WORD = 8;
    localparam int NB_OP   = 6;

    localparam logic [2:0] ST_A    = 3'd0;
    localparam logic [2:0] ST_B    = 3'd1;
    localparam logic [2:0] ST_OP   = 3'd2;
    localparam logic [2:0] ST_EVAL = 3'd3;
    localparam logic [2:0] ST_TX   = 3'd4;

    // States that take one word from the RX FIFO.
    function automatic logic is_capture_state(input logic [2:0] state);
        return (state == ST_A) || (state == ST_B) || (state == ST_OP);
    endfunction

endpackage

// File: rtl/fifo_alu_sequencer.sv
// Pops operand A, operand B and opcode from the RX FIFO, drives the ALU,
// latches its result and pushes it into the TX FIFO as one edge-clean pulse.
module fifo_alu_sequencer #(
    parameter int NB_WORD = fifo_alu_sequencer_pkg::NB_WORD,
    parameter int NB_OP   = fifo_alu_sequencer_pkg::NB_OP
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [NB_WORD-1:0] i_rx_data,
    input  logic               i_rx_empty,
    output logic               o_rx_read,
    output logic [NB_WORD-1:0] o_alu_a,
    output logic [NB_WORD-1:0] o_alu_b,
    output logic [NB_OP-1:0]   o_alu_op,
    input  logic [NB_WORD-1:0] i_alu_result,
    output logic [NB_WORD-1:0] o_tx_data,
    output logic               o_tx_write,
    input  logic               i_tx_full,
    output logic               o_busy
);

    import fifo_alu_sequencer_pkg::*;

    logic [2:0] state;
    logic       capture;

    // The FIFO flag and head word are stale while our pop is in flight, so a
    // capture is only allowed when no pop is outstanding.
    assign capture = is_capture_state(state) && !i_rx_empty && !o_rx_read;

    assign o_busy = (state != ST_A);

    // NOTE: every state and data register sits in the same reset branch with
    // non-blocking assignments, so a mid-transaction reset clears the whole
    // operand file in one edge and no block ever sees a half-updated value.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            state      <= ST_A;
            o_rx_read  <= 1'b0;
            o_tx_write <= 1'b0;
            o_alu_a    <= '0;
            o_alu_b    <= '0;
            o_alu_op   <= '0;
            o_tx_data  <= '0;
        end else begin
            o_rx_read  <= capture;
            o_tx_write <= 1'b0;
            case (state)
                ST_A: begin
                    if (capture) begin
                        o_alu_a <= i_rx_data;
                        state   <= ST_B;
                    end
                end
                ST_B: begin
                    if (capture) begin
                        o_alu_b <= i_rx_data;
                        state   <= ST_OP;
                    end
                end
                ST_OP: begin
                    if (capture) begin
                        o_alu_op <= i_rx_data[NB_OP-1:0];
                        state    <= ST_EVAL;
                    end
                end
                ST_EVAL: begin
                    o_tx_data <= i_alu_result;
                    state     <= ST_TX;
                end
                ST_TX: begin
                    // Leaving ST_TX on the push guarantees a low cycle after it.
                    if (!i_tx_full) begin
                        o_tx_write <= 1'b1;
                        state      <= ST_A;
                    end
                end
                default: state <= ST_A;
            endcase
        end
    end

endmodule

// File: doc/fifo_alu_sequencer.md
# fifo_alu_sequencer

Transaction controller between the UART receive FIFO, the ALU and the UART transmit FIFO. Pops three words from the RX FIFO (operand A, operand B, opcode), presents them to the ALU, captures the result, and pushes it into the TX FIFO. It respects the FIFO handshakes:
- RX read is level-sensitive, pops one word per cycle high, and has no empty guard.
- TX write is rising-edge-detected and has no full guard.

## Interface

Parameters:
- NB_WORD, 8, width of operands, result and FIFO words
- NB_OP, 6, opcode width; opcode is the low NB_OP bits of the third received word

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  synchronous, active-low reset
- i_rx_data  in  NB_WORD  RX FIFO head word (show-ahead, valid while i_rx_empty=0)
- i_rx_empty  in  1  RX FIFO empty flag
- o_rx_read  out  1  RX FIFO pop; registered one-cycle pulse
- o_alu_a  out  NB_WORD  registered operand A
- o_alu_b  out  NB_WORD  registered operand B
- o_alu_op  out  NB_OP  registered opcode
- i_alu_result  in  NB_WORD  combinational ALU result of o_alu_a/b/op
- o_tx_data  out  NB_WORD  registered result word for TX FIFO
- o_tx_write  out  1  TX FIFO push; registered one-cycle pulse, always followed by at least one low cycle
- i_tx_full  in  1  TX FIFO full flag
- o_busy  out  1  high in every state except ST_A

## Operation

- States: ST_A, ST_B, ST_OP, ST_EVAL, ST_TX. Reset state is ST_A.
- Capture rule, ST_A/ST_B/ST_OP: capture when i_rx_empty=0 and o_rx_read=0.
  - The captured word goes to o_alu_a, o_alu_b or o_alu_op respectively.
  - o_rx_read is set to 1 for the next cycle.
  - The state advances to ST_B, ST_OP or ST_EVAL respectively.
- While o_rx_read=1, i_rx_empty and i_rx_data are ignored, because the FIFO pointer and flag are not yet updated. This limits capture to at most one word per 2 cycles and guarantees no double pop and no pop on empty.
- ST_EVAL: lasts one cycle unconditionally. i_alu_result is latched into o_tx_data, then the state goes to ST_TX.
- ST_TX: if i_tx_full=0, set o_tx_write=1 for the next cycle and go to ST_A. If i_tx_full=1, hold with o_tx_write=0 and o_tx_data stable, indefinitely.
- o_tx_write is never high on two consecutive cycles. Every transaction produces exactly one push, so the edge detector in the TX FIFO accepts each one.
- Pipelining: ST_A may capture the next operand A in the same cycle that o_tx_write is high.
- Width rules:
  - Operands are stored unmodified.
  - Opcode = i_rx_data[NB_OP-1:0]; upper bits are discarded.
  - The result is NB_WORD bits; no overflow handling in this block.
- Reset (i_rst=0), in any state including mid-transaction:
  - Next state is ST_A.
  - o_rx_read, o_tx_write, o_alu_a, o_alu_b, o_alu_op, o_tx_data all go to 0. o_busy is 0.
  - The partial transaction is discarded. RX words already popped are lost.

## Timing

- Cycle 0 is the first cycle with i_rst=1.
- RX FIFO holds ≥3 words and the TX FIFO is not full:
  - Captures occur at the edges ending cycles 0, 2 and 4.
  - ST_EVAL is in cycle 5 and ST_TX in cycle 6.
  - o_tx_write is high in cycle 7.
- Minimum transaction period is 7 cycles when back-to-back.
- RX starvation: no upper bound on the wait in any capture state; outputs stay stable.
- TX backpressure: the push occurs on the cycle after the first ST_TX cycle that sees i_tx_full=0.
- The ALU must be combinational with settle time under one clock. o_alu_* are stable from ST_EVAL until the next capture.

## Structure

- Shared package: state encoding localparams (3 bits: ST_A=0, ST_B=1, ST_OP=2, ST_EVAL=3, ST_TX=4) and default widths NB_WORD/NB_OP, also used by the ALU and top level.
- No sub-module. The block is a single FSM with an operand register file; FIFOs and ALU are instantiated by the parent.

## Test plan

- Preload RX with 0x05, 0x03, 0x20; ALU model computes A+B for op 0x20.
  - Required: exactly 3 o_rx_read pulses, in cycles 1, 3 and 5.
  - Required: o_tx_data=0x08 and o_tx_write=1 in cycle 7 only.
- Feed RX words with 10-cycle gaps (empty between words).
  - Required: no o_rx_read while i_rx_empty=1.
  - Required: TX receives the correct result once, after the third word.
- Hold i_tx_full=1 for 20 cycles after ST_TX is reached.
  - Required: o_tx_write=0 throughout, with o_tx_data stable.
  - Required: a single push in the cycle after full is released.
- Preload 6 words for two back-to-back transactions.
  - Required: two pushes separated by ≥6 cycles.
  - Required: never two consecutive o_tx_write cycles; both results correct.
- Assert i_rst=0 for one cycle during ST_OP.
  - Required: all outputs are 0 the next cycle and the state is ST_A.
  - Required: the next 3 RX words form a fresh, correct transaction.
- Send opcode word 0xE0 with NB_OP=6.
  - Required: o_alu_op=0x20; upper bits are dropped.
